// File: rtl/serial_link_perf_pkg.sv
// Shared types for the serial-link performance measurement window controller.
package serial_link_perf_pkg;

  typedef enum logic [1:0] {
    PerfIdle  = 2'd0,
    PerfArmed = 2'd1,
    PerfRun   = 2'd2,
    PerfDone  = 2'd3
  } perf_state_e;

  typedef enum logic {
    TrigImmediate  = 1'b0,
    TrigFirstEvent = 1'b1
  } trig_mode_e;

  function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_link_sat_counter.sv
// Saturating up-counter with a sticky overflow flag; holds at all-ones instead of wrapping.
module serial_link_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o,
  output logic             ovf_o
);

  logic [Width-1:0] cnt_d, cnt_q;
  logic             ovf_d, ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + Width'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/serial_link_perf_window_ctrl.sv
// Measurement-window controller: arm, optional trigger, count cycles/events for a window, then freeze.
module serial_link_perf_window_ctrl
  import serial_link_perf_pkg::*;
#(
  parameter int unsigned CntWidth  = 32,
  parameter int unsigned WinWidth  = 32,
  parameter int unsigned NumEvents = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic                          clear_i,
  input  logic                          trig_mode_i,
  input  logic [WinWidth-1:0]           window_i,
  input  logic [NumEvents-1:0]          evt_i,
  output logic [1:0]                    state_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [CntWidth-1:0]           cycles_o,
  output logic [NumEvents*CntWidth-1:0] evt_cnt_o,
  output logic [NumEvents:0]            overflow_o
);

  localparam int unsigned CmpWidth = max_width(CntWidth, WinWidth);

  perf_state_e         state_d, state_q;
  logic [WinWidth-1:0] window_d, window_q;
  trig_mode_e          mode_d, mode_q;
  logic                busy_d, busy_q;
  logic                done_d, done_q;

  logic                cnt_en_c;
  logic                cnt_clr_c;
  logic [CntWidth-1:0] cyc_inc_c;
  logic                win_hit_c;

  // Value the cycle counter takes if this cycle is counted; saturation keeps it pinned.
  assign cyc_inc_c = (&cycles_o) ? cycles_o : cycles_o + CntWidth'(1);
  assign win_hit_c = (window_q != '0) &&
                     (CmpWidth'(cyc_inc_c) == CmpWidth'(window_q));

  always_comb begin
    state_d   = state_q;
    window_d  = window_q;
    mode_d    = mode_q;
    cnt_en_c  = 1'b0;
    cnt_clr_c = 1'b0;
    if (clear_i) begin
      state_d   = PerfIdle;
      cnt_clr_c = 1'b1;
    end else begin
      unique case (state_q)
        PerfIdle, PerfDone: begin
          if (start_i) begin
            window_d  = window_i;
            mode_d    = trig_mode_e'(trig_mode_i);
            cnt_clr_c = (state_q == PerfDone);
            state_d   = (trig_mode_i == 1'b1) ? PerfArmed : PerfRun;
          end
        end
        PerfArmed: begin
          if (stop_i) begin
            state_d = PerfDone;
          end else if (|evt_i) begin
            cnt_en_c = 1'b1;
            state_d  = win_hit_c ? PerfDone : PerfRun;
          end
        end
        PerfRun: begin
          if (stop_i) begin
            state_d = PerfDone;
          end else begin
            cnt_en_c = 1'b1;
            if (win_hit_c) begin
              state_d = PerfDone;
            end
          end
        end
        default: state_d = PerfIdle;
      endcase
    end
    busy_d = (state_d == PerfArmed) || (state_d == PerfRun);
    done_d = (state_d == PerfDone);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= PerfIdle;
      window_q <= '0;
      mode_q   <= TrigImmediate;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  serial_link_sat_counter #(.Width(CntWidth)) u_cyc_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr_c),
    .en_i  (cnt_en_c),
    .cnt_o (cycles_o),
    .ovf_o (overflow_o[NumEvents])
  );

  for (genvar i = 0; i < NumEvents; i++) begin : g_evt_cnt
    serial_link_sat_counter #(.Width(CntWidth)) u_evt_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (cnt_clr_c),
      .en_i  (cnt_en_c & evt_i[i]),
      .cnt_o (evt_cnt_o[i*CntWidth +: CntWidth]),
      .ovf_o (overflow_o[i])
    );
  end

  assign state_o = state_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_serial_link_perf_window_ctrl.sv
// Directed bench for the perf window controller: 32-bit build plus a 4-bit build for saturation.
module tb_serial_link_perf_window_ctrl;

  localparam int unsigned NE  = 4;
  localparam int unsigned CW  = 32;
  localparam int unsigned WW  = 32;
  localparam int unsigned SCW = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, stop, clear, mode;
  logic [WW-1:0]     window;
  logic [NE-1:0]     evt;

  logic [1:0]        state_o, state_s;
  logic              busy_o, done_o, busy_s, done_s;
  logic [CW-1:0]     cycles_o;
  logic [NE*CW-1:0]  evt_cnt_o;
  logic [NE:0]       ovf_o, ovf_s;
  logic [SCW-1:0]    cycles_s;
  logic [NE*SCW-1:0] evt_cnt_s;

  serial_link_perf_window_ctrl #(.CntWidth(CW), .WinWidth(WW), .NumEvents(NE)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .clear_i(clear),
    .trig_mode_i(mode), .window_i(window), .evt_i(evt),
    .state_o(state_o), .busy_o(busy_o), .done_o(done_o), .cycles_o(cycles_o),
    .evt_cnt_o(evt_cnt_o), .overflow_o(ovf_o)
  );

  serial_link_perf_window_ctrl #(.CntWidth(SCW), .WinWidth(WW), .NumEvents(NE)) u_dut_small (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .clear_i(clear),
    .trig_mode_i(mode), .window_i(window), .evt_i(evt),
    .state_o(state_s), .busy_o(busy_s), .done_o(done_s), .cycles_o(cycles_s),
    .evt_cnt_o(evt_cnt_s), .overflow_o(ovf_s)
  );

  typedef struct {
    logic [1:0]       st;
    logic [CW-1:0]    cyc;
    logic [NE*CW-1:0] ev;
    logic [NE:0]      ov;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [NE*CW-1:0] obs, input logic [NE*CW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NE*CW-1:0] ev1(input int idx, input logic [CW-1:0] v);
    logic [NE*CW-1:0] r;
    r = '0;
    r[idx*CW +: CW] = v;
    return r;
  endfunction

  task automatic push_exp(input logic [1:0] st, input logic [CW-1:0] cyc,
                          input logic [NE*CW-1:0] ev, input logic [NE:0] ov);
    exp_t e;
    e.st = st; e.cyc = cyc; e.ev = ev; e.ov = ov;
    sb_q.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    n_assert++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, ".state"},   state_o,   e.st);
      chk({tag, ".busy"},    busy_o,    (e.st == S_ARMED) || (e.st == S_RUN));
      chk({tag, ".done"},    done_o,    e.st == S_DONE);
      chk({tag, ".cycles"},  cycles_o,  e.cyc);
      chk({tag, ".evt_cnt"}, evt_cnt_o, e.ev);
      chk({tag, ".ovf"},     ovf_o,     e.ov);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m, input logic [WW-1:0] w);
    mode = m; window = w; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done_o; n returns the number of cycles waited.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done_o && n < 200) begin
      tick();
      n++;
    end
    chk({tag, ".done_timeout"}, done_o, 1'b1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; mode = 1'b0;
    window = '0; evt = '0;
    tick(); tick();
    rst = 1'b0;
    push_exp(S_IDLE, 0, '0, '0);
    check_sb("reset");

    // 1: immediate, window 10, event 0 every cycle
    evt = 4'b0001;
    do_start(1'b0, 10);
    chk("t1.run_state", state_o, S_RUN);
    push_exp(S_DONE, 10, ev1(0, 10), '0);
    wait_done("t1", n);
    chk("t1.run_len", n, 10);
    check_sb("t1.result");
    tick(); tick(); tick();
    push_exp(S_DONE, 10, ev1(0, 10), '0);
    check_sb("t1.frozen");

    // 2: trigger mode, window 5, restart from DONE clears counters
    evt = '0;
    do_start(1'b1, 5);
    push_exp(S_ARMED, 0, '0, '0);
    check_sb("t2.armed_cleared");
    for (int i = 0; i < 7; i++) tick();
    chk("t2.still_armed", state_o, S_ARMED);
    evt = 4'b0010;
    tick();
    evt = '0;
    chk("t2.trig_cycles", cycles_o, 1);
    push_exp(S_DONE, 5, ev1(1, 1), '0);
    wait_done("t2", n);
    chk("t2.run_len", n, 4);
    check_sb("t2.result");

    // 3: unbounded, alternate events on bit 2, stop after 8 cycles
    do_start(1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      evt = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      tick();
    end
    evt = 4'b0100; stop = 1'b1;
    tick();
    stop = 1'b0; evt = '0;
    push_exp(S_DONE, 8, ev1(2, 4), '0);
    check_sb("t3.result");

    // 4: saturation on the 4-bit build
    clear = 1'b1;
    tick();
    clear = 1'b0;
    push_exp(S_IDLE, 0, '0, '0);
    check_sb("t4.cleared");
    evt = 4'b1000;
    do_start(1'b0, 0);
    for (int i = 0; i < 15; i++) tick();
    chk("t4.small_cyc15", cycles_s, 4'd15);
    chk("t4.small_no_ovf", ovf_s, 5'b00000);
    for (int i = 0; i < 5; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0; evt = '0;
    chk("t4.small_state", state_s, S_DONE);
    chk("t4.small_cycles", cycles_s, 4'd15);
    chk("t4.small_evt", evt_cnt_s, 16'hF000);
    chk("t4.small_ovf", ovf_s, 5'b11000);
    push_exp(S_DONE, 20, ev1(3, 20), '0);
    check_sb("t4.wide");

    // 5: start ignored in RUN, clear beats stop, restarts from DONE
    evt = 4'b0001;
    do_start(1'b0, 0);
    tick(); tick(); tick();
    start = 1'b1; window = 2;
    tick();
    start = 1'b0;
    push_exp(S_RUN, 4, ev1(0, 4), '0);
    check_sb("t5.start_ignored");
    clear = 1'b1; stop = 1'b1;
    tick();
    clear = 1'b0; stop = 1'b0;
    push_exp(S_IDLE, 0, '0, '0);
    check_sb("t5.clear_stop");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5.stop_idle", state_o, S_IDLE);
    do_start(1'b0, 3);
    push_exp(S_DONE, 3, ev1(0, 3), '0);
    wait_done("t5a", n);
    check_sb("t5.first");
    do_start(1'b0, 1);
    push_exp(S_RUN, 0, '0, '0);
    check_sb("t5.restart_zero");
    push_exp(S_DONE, 1, ev1(0, 1), '0);
    wait_done("t5b", n);
    chk("t5.win1_len", n, 1);
    check_sb("t5.win1");

    // 6: reset mid-run, then window 1 in trigger mode, then stop in ARMED
    evt = '0;
    do_start(1'b0, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("t6.pre_rst_cycles", cycles_o, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_exp(S_IDLE, 0, '0, '0);
    check_sb("t6.after_rst");
    do_start(1'b1, 1);
    chk("t6.armed", state_o, S_ARMED);
    evt = 4'b0001;
    tick();
    evt = '0;
    push_exp(S_DONE, 1, ev1(0, 1), '0);
    check_sb("t6.win1_trig");
    do_start(1'b1, 5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    push_exp(S_DONE, 0, '0, '0);
    check_sb("t6.stop_armed");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
